// File: rtl/cache_pkg.sv
// Shared types and constants for the cache/main-memory arbiter.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin arbiter; the priority register lives in the parent.
module rr_arb2
  import cache_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // Pick the sole requester, or the prio port when both request.
  always_comb begin
    gnt    = '0;
    gnt_id = PORT_I;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = PORT_I;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = PORT_D;
      end
      2'b11: begin
        gnt    = prio ? 2'b10 : 2'b01;
        gnt_id = prio;
      end
      default: begin
        gnt    = '0;
        gnt_id = PORT_I;
      end
    endcase
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between the I-cache (port 0) and D-cache (port 1),
// one transaction at a time, with round-robin arbitration and an ack timeout.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // A zero TIMEOUT still needs a 1-bit counter to keep the vector legal.
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_t           r_state;
  logic             r_prio;
  logic             r_cur;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_gnt;
  logic             w_gnt_id;

  rr_arb2 u_arb (
    .req    (req),
    .prio   (r_prio),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  // Transaction FSM: grant in IDLE, wait for ack/timeout in BUSY, pulse done in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_prio    <= 1'b0;
      r_cur     <= 1'b0;
      r_cnt     <= '0;
      done      <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done <= '0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_state   <= BUSY;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            r_cur     <= w_gnt_id;
            r_prio    <= ~w_gnt_id;
            r_cnt     <= '0;
            mem_we    <= |(we & w_gnt);
            mem_addr  <= w_gnt[1] ? addr1  : addr0;
            mem_wdata <= w_gnt[1] ? wdata1 : wdata0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            rdata   <= mem_we ? '0 : mem_rdata;
            err     <= 1'b0;
            mem_req <= 1'b0;
            done    <= r_cur ? 2'b10 : 2'b01;
            r_state <= DONE;
          end else if (TO_EN && (r_cnt == CNT_LAST)) begin
            rdata   <= '0;
            err     <= 1'b1;
            mem_req <= 1'b0;
            done    <= r_cur ? 2'b10 : 2'b01;
            r_state <= DONE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
